// File: rtl/pc_unit.sv
// Program-counter unit: holds the architectural PC, the registered link value
// (pc+1), and evaluates condition codes for conditional jumps and branches.
module pc_unit #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             npc_ctrl,
  input  logic             is_branch,
  input  logic [3:0]       cond,
  input  logic [7:0]       disp,
  input  logic [WIDTH-1:0] target,
  input  logic [4:0]       flags,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link,
  output logic             taken,
  output logic             hold
);

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_HI = 4'b0100, CC_LS = 4'b0101, CC_GT = 4'b0110, CC_LE = 4'b0111,
    CC_FS = 4'b1000, CC_FC = 4'b1001, CC_LO = 4'b1010, CC_HS = 4'b1011,
    CC_LT = 4'b1100, CC_GE = 4'b1101, CC_UC = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    UPD_IDLE,
    UPD_REDIRECT,
    UPD_SWALLOW,
    UPD_INCR
  } upd_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] link_q, link_d;
  logic             taken_q, taken_d;
  logic             hold_q, hold_d;

  logic             f_c, f_l, f_f, f_z, f_n;
  logic             cond_true;
  cond_e            cond_code;
  upd_e             upd;
  logic [WIDTH-1:0] disp_ext;

  assign {f_c, f_l, f_f, f_z, f_n} = flags;
  assign cond_code = cond_e'(cond);
  assign disp_ext  = {{(WIDTH-8){disp[7]}}, disp};

  // Condition-code evaluation against the PSR flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      CC_EQ: cond_true = f_z;
      CC_NE: cond_true = !f_z;
      CC_CS: cond_true = f_c;
      CC_CC: cond_true = !f_c;
      CC_HI: cond_true = f_l;
      CC_LS: cond_true = !f_l;
      CC_GT: cond_true = f_n;
      CC_LE: cond_true = !f_n;
      CC_FS: cond_true = f_f;
      CC_FC: cond_true = !f_f;
      CC_LO: cond_true = !f_l && !f_z;
      CC_HS: cond_true = f_l || f_z;
      CC_LT: cond_true = !f_n && !f_z;
      CC_GE: cond_true = f_n || f_z;
      CC_UC: cond_true = 1'b1;
      CC_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Select the kind of PC update in priority order (reset handled in the flops)
  always_comb begin
    upd = UPD_IDLE;
    if (pc_en) begin
      if (npc_ctrl)    upd = UPD_REDIRECT;
      else if (hold_q) upd = UPD_SWALLOW;
      else             upd = UPD_INCR;
    end
  end

  // Next-state computation; link tracks the new pc so it is never combinational
  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    hold_d  = hold_q;
    case (upd)
      UPD_REDIRECT: begin
        taken_d = cond_true;
        hold_d  = 1'b1;
        if (!cond_true)     pc_d = pc_q + WIDTH'(1);
        else if (is_branch) pc_d = pc_q + disp_ext;
        else                pc_d = target;
      end
      UPD_SWALLOW: hold_d = 1'b0;
      UPD_INCR:    pc_d   = pc_q + WIDTH'(1);
      default: ;
    endcase
    link_d = pc_d + WIDTH'(1);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      link_q  <= RESET_VEC + WIDTH'(1);
      taken_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      link_q  <= link_d;
      taken_q <= taken_d;
      hold_q  <= hold_d;
    end
  end

  assign pc    = pc_q;
  assign link  = link_q;
  assign taken = taken_q;
  assign hold  = hold_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vectors, a behavioural reference model checked
// every cycle, and hand-computed literal expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, pc_en, npc_ctrl, is_branch;
  logic [3:0]  cond;
  logic [7:0]  disp;
  logic [15:0] target;
  logic [4:0]  flags;
  logic [15:0] pc, link;
  logic        taken, hold;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  int m_pc    = 0;
  bit m_taken = 1'b0;
  bit m_hold  = 1'b0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .npc_ctrl(npc_ctrl),
    .is_branch(is_branch), .cond(cond), .disp(disp), .target(target),
    .flags(flags), .pc(pc), .link(link), .taken(taken), .hold(hold)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    bit fc, fl, ff, fz, fn;
    fc = f[4]; fl = f[3]; ff = f[2]; fz = f[1]; fn = f[0];
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fl;
      4'd5:  return !fl;
      4'd6:  return fn;
      4'd7:  return !fn;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !fl && !fz;
      4'd11: return fl || fz;
      4'd12: return !fn && !fz;
      4'd13: return fn || fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: integer PC arithmetic modulo 2^16
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_taken = 1'b0; m_hold = 1'b0;
    end else if (pc_en) begin
      if (npc_ctrl) begin
        m_taken = cond_ok(cond, flags);
        m_hold  = 1'b1;
        if (!m_taken)       m_pc = (m_pc + 1) % 65536;
        else if (is_branch) m_pc = (m_pc + int'($signed(disp)) + 65536) % 65536;
        else                m_pc = int'(target);
      end else if (m_hold) begin
        m_hold = 1'b0;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("model_pc",    32'(pc),    32'(m_pc));
      chk("model_link",  32'(link),  32'((m_pc + 1) % 65536));
      chk("model_taken", 32'(taken), 32'(m_taken));
      chk("model_hold",  32'(hold),  32'(m_hold));
    end
  end

  task automatic cyc(input logic rst, input logic en, input logic nc, input logic br,
                     input logic [3:0] cd, input logic [7:0] dp,
                     input logic [15:0] tg, input logic [4:0] fl);
    reset = rst; pc_en = en; npc_ctrl = nc; is_branch = br;
    cond = cd; disp = dp; target = tg; flags = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 5'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 5'b0);
  endtask

  task automatic redirect(input logic br, input logic [3:0] cd, input logic [7:0] dp,
                          input logic [15:0] tg, input logic [4:0] fl);
    cyc(1'b0, 1'b1, 1'b1, br, cd, dp, tg, fl);
  endtask

  // Unconditional register jump followed by the swallowed pc_en, leaving hold=0
  task automatic set_pc(input logic [15:0] v);
    redirect(1'b0, 4'hE, 8'h00, v, 5'b0);
    pulse();
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'h0000, 5'b0);
    checking = 1'b1;
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_link", 32'(link), 32'h0001);
    chk("rst_taken", 32'(taken), 32'h0);
    chk("rst_hold", 32'(hold), 32'h0);

    pulse(); pulse(); pulse();
    chk("inc3_pc", 32'(pc), 32'h0003);
    chk("inc3_link", 32'(link), 32'h0004);

    // FSM jump pattern
    set_pc(16'h0010);
    redirect(1'b0, 4'hE, 8'h00, 16'h1234, 5'b0);
    chk("jmp_pc", 32'(pc), 32'h1234);
    chk("jmp_taken", 32'(taken), 32'h1);
    chk("jmp_hold1", 32'(hold), 32'h1);
    idle();
    chk("jmp_idle_pc", 32'(pc), 32'h1234);
    chk("jmp_idle_hold", 32'(hold), 32'h1);
    pulse();
    chk("jmp_swallow_pc", 32'(pc), 32'h1234);
    chk("jmp_swallow_hold", 32'(hold), 32'h0);
    chk("jmp_swallow_link", 32'(link), 32'h1235);

    // EQ branch, taken and not taken
    set_pc(16'h0100);
    redirect(1'b1, 4'h0, 8'hFE, 16'h0000, 5'b00010);
    chk("beq_t_pc", 32'(pc), 32'h00FE);
    chk("beq_t_taken", 32'(taken), 32'h1);
    set_pc(16'h0100);
    redirect(1'b1, 4'h0, 8'hFE, 16'h0000, 5'b00000);
    chk("beq_nt_pc", 32'(pc), 32'h0101);
    chk("beq_nt_taken", 32'(taken), 32'h0);
    chk("beq_nt_hold", 32'(hold), 32'h1);

    // Full condition sweep on register jumps (back-to-back redirects are legal)
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 32; f++)
        redirect(1'b0, 4'(c), 8'h00, 16'h0ABC, 5'(f));
    pulse();

    redirect(1'b0, 4'hA, 8'h00, 16'h0ABC, 5'b00000);
    chk("lo_pc", 32'(pc), 32'h0ABC);
    chk("lo_taken", 32'(taken), 32'h1);
    redirect(1'b0, 4'hF, 8'h00, 16'h1111, 5'b11111);
    chk("nv_pc", 32'(pc), 32'h0ABD);
    chk("nv_taken", 32'(taken), 32'h0);
    redirect(1'b0, 4'hC, 8'h00, 16'h2222, 5'b00001);
    chk("lt_false_pc", 32'(pc), 32'h0ABE);

    // Wrap cases
    set_pc(16'hFFFF);
    chk("wrap_link_ffff", 32'(link), 32'h0000);
    pulse();
    chk("wrap_pc", 32'(pc), 32'h0000);
    chk("wrap_link", 32'(link), 32'h0001);
    set_pc(16'h0005);
    redirect(1'b1, 4'hE, 8'h80, 16'h0000, 5'b0);
    chk("br_neg128_pc", 32'(pc), 32'hFF85);

    // pc_en low ignores npc_ctrl
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 8'h00, 16'h5555, 5'b0);
    chk("noen_pc", 32'(pc), 32'hFF85);
    chk("noen_hold", 32'(hold), 32'h1);

    // Reset wins over a simultaneous redirect while hold=1
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'hE, 8'h00, 16'h7777, 5'b0);
    chk("midrst_pc", 32'(pc), 32'h0000);
    chk("midrst_hold", 32'(hold), 32'h0);
    chk("midrst_taken", 32'(taken), 32'h0);
    pulse();
    chk("postrst_pc", 32'(pc), 32'h0001);
    idle();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
